// File: rtl/l2_cache_control_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// l2_cache_control_pkg : shared types for the 2-way, 8-set L2 cache controller
// Revision: 1.0
// ============================================================================
package l2_cache_control_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } l2_state_t;

    typedef logic [1:0] pmem_addr_sel_t;

    localparam pmem_addr_sel_t PMEM_SEL_REQ  = 2'b00;
    localparam pmem_addr_sel_t PMEM_SEL_WAY0 = 2'b01;
    localparam pmem_addr_sel_t PMEM_SEL_WAY1 = 2'b10;

endpackage
`default_nettype wire

// File: rtl/l2_cache_control_sat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// l2_cache_control_sat_counter : up-counter that sticks at all-ones
// Revision: 1.0
// ============================================================================
module l2_cache_control_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/l2_cache_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// l2_cache_control : hit/miss FSM, LRU victim write-back and line allocation
// Revision: 1.0
// ============================================================================
module l2_cache_control
    import l2_cache_control_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 dirty0,
    input  logic                 dirty1,
    input  logic                 lru_out,
    output logic                 load_word0,
    output logic                 load_word1,
    output logic                 load_line0,
    output logic                 load_line1,
    output logic                 lru_load,
    output logic                 lru_in,
    output logic                 dout_sel,
    output logic [1:0]           pmem_addr_sel,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    l2_state_t state_q, state_d;
    logic      victim_q, victim_d;
    logic      refill_q, refill_d;

    logic w_hit;
    logic w_hit_way;
    logic w_hit_inc;
    logic w_miss_inc;

    assign w_hit     = hit0 | hit1;
    // way0 takes priority if both ways report a hit
    assign w_hit_way = ~hit0;

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        refill_d      = refill_q;
        mem_resp      = 1'b0;
        load_word0    = 1'b0;
        load_word1    = 1'b0;
        load_line0    = 1'b0;
        load_line1    = 1'b0;
        lru_load      = 1'b0;
        lru_in        = 1'b0;
        dout_sel      = 1'b0;
        pmem_addr_sel = PMEM_SEL_REQ;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        w_hit_inc     = 1'b0;
        w_miss_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                refill_d = 1'b0;
                if (w_hit) begin
                    mem_resp   = 1'b1;
                    dout_sel   = w_hit_way;
                    lru_load   = 1'b1;
                    lru_in     = ~w_hit_way;
                    // a simultaneous read+write request is serviced as a write
                    load_word0 = mem_write & ~w_hit_way;
                    load_word1 = mem_write &  w_hit_way;
                    w_hit_inc  = ~refill_q;
                    state_d    = IDLE;
                end else begin
                    victim_d   = lru_out;
                    w_miss_inc = 1'b1;
                    state_d    = (lru_out ? dirty1 : dirty0) ? WRITEBACK : ALLOCATE;
                end
            end

            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = victim_q ? PMEM_SEL_WAY1 : PMEM_SEL_WAY0;
                dout_sel      = victim_q;
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = PMEM_SEL_REQ;
                if (pmem_resp) begin
                    load_line0 = ~victim_q;
                    load_line1 =  victim_q;
                    refill_d   = 1'b1;
                    state_d    = CHECK;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
            refill_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            refill_q <= refill_d;
        end
    end

    l2_cache_control_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_hit_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (w_hit_inc),
        .count_o (hit_count)
    );

    l2_cache_control_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_miss_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (w_miss_inc),
        .count_o (miss_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_l2_cache_control : directed stimulus with a mem_resp-driven scoreboard
// Revision: 1.0
// ============================================================================
module tb_l2_cache_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read = 1'b0, mem_write = 1'b0, mem_resp;
    logic          hit0 = 1'b0, hit1 = 1'b0, dirty0 = 1'b0, dirty1 = 1'b0, lru_out = 1'b0;
    logic          load_word0, load_word1, load_line0, load_line1;
    logic          lru_load, lru_in, dout_sel;
    logic [1:0]    pmem_addr_sel;
    logic          pmem_read, pmem_write;
    logic          pmem_resp = 1'b0;
    logic [CW-1:0] hit_count, miss_count;

    l2_cache_control #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_resp      (mem_resp),
        .hit0          (hit0),
        .hit1          (hit1),
        .dirty0        (dirty0),
        .dirty1        (dirty1),
        .lru_out       (lru_out),
        .load_word0    (load_word0),
        .load_word1    (load_word1),
        .load_line0    (load_line0),
        .load_line1    (load_line1),
        .lru_load      (lru_load),
        .lru_in        (lru_in),
        .dout_sel      (dout_sel),
        .pmem_addr_sel (pmem_addr_sel),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_resp     (pmem_resp),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dsel;
        logic          lru_in;
        logic          lw0;
        logic          lw1;
        logic [CW-1:0] hc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   hc_m   = 0;
    int   mc_m   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Response monitor: pops an expectation on every mem_resp pulse
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (mem_resp === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_mem_resp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_dout_sel", dout_sel, e.dsel);
                    chk("resp_lru_load", lru_load, 1'b1);
                    chk("resp_lru_in", lru_in, e.lru_in);
                    chk("resp_load_word", {load_word0, load_word1}, {e.lw0, e.lw1});
                    chk("resp_no_pmem_no_line", {pmem_read, pmem_write, load_line0, load_line1}, 4'b0);
                    @(negedge clk); #1;
                    chk("hit_count", hit_count, e.hc);
                    chk("miss_count", miss_count, e.mc);
                end
            end
        end
    end

    // One upstream request; datapath and pmem are played by this task
    task automatic do_req(input bit rd, input bit wr, input bit h0, input bit h1,
                          input bit lru, input bit d0, input bit d1, input int lat);
        exp_t e;
        bit   v;
        if (h0 || h1) begin
            v = h0 ? 1'b0 : 1'b1;
            if (hc_m < 15) hc_m++;
        end else begin
            v = lru;
            if (mc_m < 15) mc_m++;
        end
        e.dsel   = v;
        e.lru_in = ~v;
        e.lw0    = wr && !v;
        e.lw1    = wr && v;
        e.hc     = CW'(hc_m);
        e.mc     = CW'(mc_m);
        q.push_back(e);

        @(negedge clk);
        mem_read = rd; mem_write = wr;
        hit0 = h0; hit1 = h1; lru_out = lru; dirty0 = d0; dirty1 = d1;
        @(negedge clk);
        if (!(h0 || h1)) begin
            if (v ? d1 : d0) begin
                @(negedge clk); #1;
                chk("wb_pmem", {pmem_write, pmem_read}, 2'b10);
                chk("wb_addr_sel", pmem_addr_sel, v ? 2'b10 : 2'b01);
                chk("wb_dout_sel", dout_sel, v);
                repeat (lat - 1) @(negedge clk);
                pmem_resp = 1'b1;
                @(negedge clk);
                pmem_resp = 1'b0;
            end else begin
                @(negedge clk);
            end
            #1;
            chk("alloc_pmem", {pmem_write, pmem_read}, 2'b01);
            chk("alloc_addr_sel", pmem_addr_sel, 2'b00);
            repeat (lat - 1) @(negedge clk);
            pmem_resp = 1'b1; #1;
            chk("alloc_load_line", {load_line0, load_line1}, {!v, v});
            if (v) hit1 = 1'b1; else hit0 = 1'b1;
            @(negedge clk);
            pmem_resp = 1'b0;
        end
        #1;
        chk("mem_resp_timing", mem_resp, 1'b1);
        @(negedge clk);
        mem_read = 0; mem_write = 0; hit0 = 0; hit1 = 0; dirty0 = 0; dirty1 = 0; lru_out = 0;
    endtask

    initial begin : stim
        #2;
        chk("reset_outputs", {mem_resp, load_word0, load_word1, load_line0, load_line1, lru_load,
                              lru_in, dout_sel, pmem_addr_sel, pmem_read, pmem_write}, 12'b0);
        chk("reset_counters", {hit_count, miss_count}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // read hit on way1
        do_req(1, 0, 0, 1, 0, 0, 0, 0);

        // reset while ALLOCATE is waiting on pmem
        @(negedge clk);
        mem_read = 1'b1; lru_out = 1'b0; dirty0 = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("pre_reset_pmem_read", pmem_read, 1'b1);
        rst_n = 1'b0; #1;
        chk("reset_drops_pmem_read", pmem_read, 1'b0);
        mem_read = 1'b0; hc_m = 0; mc_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_after_reset", {pmem_read, pmem_write, mem_resp}, 3'b0);
        chk("counters_after_reset", {hit_count, miss_count}, 8'h00);

        // stray pmem_resp in IDLE must not move the FSM
        pmem_resp = 1'b1;
        @(negedge clk); #1;
        pmem_resp = 1'b0;
        chk("idle_pmem_resp_ignored", {load_line0, load_line1, pmem_read, mem_resp}, 4'b0);
        @(negedge clk); #1;
        chk("still_idle", {pmem_read, pmem_write}, 2'b0);

        // clean read miss, victim way0, pmem latency 5
        do_req(1, 0, 0, 0, 0, 0, 0, 5);
        // dirty write miss, victim way1
        do_req(0, 1, 0, 0, 1, 0, 1, 3);
        // dirty read miss, victim way0
        do_req(1, 0, 0, 0, 0, 1, 0, 2);
        // both ways hit on a write
        do_req(0, 1, 1, 1, 0, 0, 0, 0);
        // read+write together handled as a write hit on way1
        do_req(1, 1, 0, 1, 0, 0, 0, 0);
        // run hit_count into saturation
        for (int i = 0; i < 20; i++) begin
            do_req(1, 0, (i % 2) == 0, (i % 2) == 1, 0, 0, 0, 0);
        end

        repeat (3) @(negedge clk);
        #1;
        chk("saturated_hit_count", hit_count, 4'hF);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
